// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;
  localparam int unsigned DATA_BITS  = 8;

  // Base tick divider, rounded to nearest: round(freq / (16 * baud)).
  function automatic int unsigned calc_div0(input int unsigned freq, input int unsigned baud);
    longint unsigned den;
    den = longint'(OVERSAMPLE) * longint'(baud);
    return 32'((longint'(freq) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: free-running divider of DIV0 << rate.
// The rate select is only captured while the receiver is idle, so a
// change mid-frame waits for the next IDLE.
`timescale 1ns/1ps
module uart_rx_tick_gen #(
  parameter logic [15:0] DIV0 = 16'd7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] rate_i,
  input  logic       rate_load,
  output logic       tick_o
);

  logic [1:0]  rate_q;
  logic [15:0] cnt;
  logic [15:0] div;
  logic        wrap;

  assign div  = DIV0 << rate_q;
  // >= rather than == so a shorter divider taking effect with the count
  // already above it wraps at once instead of running through 65535.
  assign wrap = (cnt >= div - 16'd1);
  assign tick_o = wrap;

  // Rate select latch, transparent only in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         rate_q <= '0;
    else if (rate_load) rate_q <= rate_i;
  end

  // Divider counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling and a one-entry holding register.
// Define UART_RX_MAJORITY_EN to insert a 3-sample majority filter on the
// tick-sampled line (rejects low glitches shorter than 2 ticks).
`timescale 1ns/1ps
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned FREQ     = 100_000_000,
  parameter int unsigned BAUDRATE = 921_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] rate_i,
  input  logic       rxd_i,
  input  logic       data_ready_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o,
  output logic       tick_o
);

  localparam logic [15:0] DIV0      = 16'(calc_div0(FREQ, BAUDRATE));
  localparam logic [3:0]  MID_LAST  = 4'(MID_TICK - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);

  state_t     state;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic [1:0] sync_q;
  logic       line;
  logic       rx_s;
  logic       tick;
  logic       stop_sample;
  logic       good;
  logic       bad;

  uart_rx_tick_gen #(
    .DIV0 (DIV0)
  ) u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rate_i    (rate_i),
    .rate_load (state == IDLE),
    .tick_o    (tick)
  );

  assign tick_o = tick;
  assign busy_o = (state != IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd_i};
  end

  assign line = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] maj_q;

  // History of the last three tick samples for the majority vote.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    maj_q <= 3'b111;
    else if (tick) maj_q <= {maj_q[1:0], line};
  end

  assign rx_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
`else
  assign rx_s = line;
`endif

  assign stop_sample = (state == STOP) && tick && (tcnt == BIT_LAST);
  assign good        = stop_sample && rx_s;
  assign bad         = stop_sample && !rx_s;

  // Frame FSM: start detection, mid-bit sampling and LSB-first shifting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            tcnt  <= '0;
            state <= START;
          end
        end
        START: begin
          if (tcnt == MID_LAST) begin
            tcnt <= '0;
            bcnt <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        DATA: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == BIT_LAST) begin
            shreg <= {rx_s, shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == DATA_LAST) state <= STOP;
          end
        end
        STOP: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == BIT_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register, handshake and error pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o <= bad;
      overrun_o   <= 1'b0;
      if (good) begin
        if (!data_valid_o || data_ready_i) begin
          data_o       <= shreg;
          data_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver for the 8N1 link driven by the team's UART transmitter. It takes the asynchronous serial line, synchronises and optionally filters it, and recovers bytes with 16x oversampling. Baud selection uses the same `rate_i` encoding as the transmitter. Each received byte goes to a one-entry holding register with a valid/ready handshake toward the consumer.

## Interface
- `FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUDRATE`, 921_600, base baud rate, selected when `rate_i` = 0.
- `clk_i`  input  1  system clock; all logic on its rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `rate_i`  input  2  baud select: tick divider = `DIV0 << rate_i`.
- `rxd_i`  input  1  serial line, asynchronous; idles high.
- `data_ready_i`  input  1  consumer accepts `data_o` when it is high in a cycle where `data_valid_o` is high.
- `data_o`  output  8  received byte, LSB first on the line.
- `data_valid_o`  output  1  holding register full.
- `frame_err_o`  output  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_o`  output  1  one-cycle pulse when a byte is dropped because the holding register is full.
- `busy_o`  output  1  high in every FSM state except IDLE.
- `tick_o`  output  1  oversampling tick, one cycle wide.

## Operation
- `DIV0` = round(FREQ / (16 * BAUDRATE)); with the defaults this is 7.
- Tick counter is 16 bits. `tick_o` pulses once every `DIV0 << rate_i` clocks.
- `rate_i` is latched only in IDLE. Changes during a frame take effect at the next IDLE.
- `rxd_i` passes through a 2-FF synchroniser that resets to 1. It is sampled into the line value `rx_s` on each tick.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with `rx_s` = 0, clear the tick count and go to START.
  - START: after 8 ticks (mid-bit), re-sample `rx_s`.
    - If `rx_s` = 1, it is a false start: return to IDLE with no outputs.
    - If `rx_s` = 0, clear the tick count and go to DATA.
  - DATA: every 16 ticks, shift `rx_s` into bit position 7 of the shift register (LSB first). After 8 bits, go to STOP.
  - STOP: after 16 ticks, sample `rx_s`.
    - If 1: the frame is good; deliver it.
    - If 0: pulse `frame_err_o`, discard the byte.
    - In both cases return to IDLE.
- Delivery of a good frame:
  - Register empty: load `data_o` and set `data_valid_o`.
  - Register full and `data_ready_i` = 0: keep the old byte and pulse `overrun_o`.
  - Register full and `data_ready_i` = 1 in the same cycle: the old byte transfers, the new byte loads, `data_valid_o` stays 1, no overrun.
- Handshake: `data_valid_o` clears on the clock edge where `data_valid_o` && `data_ready_i`. `data_o` holds its value until the next load.

## Timing
- Reset value of every output is 0, including `data_o` = 8'h00. The FSM resets to IDLE and the tick counter to 0.
- Reset mid-frame: the frame is abandoned immediately. The FSM is in IDLE after reset release. Any line low at release is handled as a normal start.
- Synchroniser latency: 2 clocks from `rxd_i` to the synchronised line.
- `data_valid_o`, `frame_err_o` and `overrun_o` assert 1 clock after the tick at which the stop bit is sampled.
- A frame occupies 9.5 bit times (start through stop mid-bit) before delivery. The FSM is back in IDLE in time to catch a back-to-back start edge.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - `rx_s` = majority of the last 3 tick samples, using a 3-bit shift register that resets to 3'b111.
  - Any low pulse shorter than 2 ticks never reaches the FSM.
  - Adds 1 tick of latency to the whole frame; sample points are unchanged relative to the filtered line.
- Not defined: `rx_s` = the single synchronised sample taken on each tick, with no filtering.

## Structure
- `uart_rx_pkg` holds:
  - `state_t` enum (IDLE, START, DATA, STOP);
  - `OVERSAMPLE` = 16, `MID_TICK` = 8, `DATA_BITS` = 8;
  - function `calc_div0(FREQ, BAUDRATE)`.
- Sub-module `uart_rx_tick_gen`: divider plus `rate_i` latch, producing `tick_o`.
- The FSM, shift register and holding register live in `uart_rx_core`.

## Test plan
Defaults apply: `DIV0` = 7, 112 clocks per bit at `rate_i` = 0.
- 8'h0F framed at `rate_i` = 0, `data_ready_i` = 1 -> `data_o` = 8'h0F, one `data_valid_o` cycle, `frame_err_o` stays 0.
- Idle line driven low for 4 ticks (28 clocks), then high -> false start: `busy_o` pulses, no valid, no error. With the macro defined, a low pulse of 1 tick (7 clocks) -> `busy_o` never rises.
- 8'h55 with stop bit 0 -> `frame_err_o` pulses once, `data_valid_o` stays 0, next frame 8'h01 is received correctly.
- Back-to-back 8'hA5 then 8'h5A with `data_ready_i` = 0 -> `data_o` stays 8'hA5, `overrun_o` pulses at the second stop bit. A later `data_ready_i` pulse clears `data_valid_o`.
- `rate_i` = 2 with 8'h3C (448 clocks per bit) -> received correctly; switching `rate_i` to 0 mid-frame does not corrupt the byte.
- `rst_i` low during DATA bit 3 -> all outputs 0 asynchronously; after release, 8'hC3 is received correctly.
